// File: rtl/rapid_pkg.sv
// rtl/rapid_pkg.sv - shared decode types, RV32I opcode constants and opcode classifier
package rapid_pkg;

    typedef enum logic [1:0] {
        ID_EMPTY = 2'd0,
        ID_VALID = 2'd1,
        ID_HALT  = 2'd2
    } id_state_t;

    typedef enum logic [3:0] {
        ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, ILLEGAL
    } instr_class_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // Full 7-bit match, so any word whose low two bits are not 2'b11 falls to ILLEGAL.
    function automatic instr_class_t classify(input logic [6:0] opcode);
        instr_class_t cls;
        case (opcode)
            OPC_OP:     cls = ALU_R;
            OPC_OP_IMM: cls = ALU_I;
            OPC_LOAD:   cls = LOAD;
            OPC_STORE:  cls = STORE;
            OPC_BRANCH: cls = BRANCH;
            OPC_JAL:    cls = JAL;
            OPC_JALR:   cls = JALR;
            OPC_LUI:    cls = LUI;
            OPC_AUIPC:  cls = AUIPC;
            OPC_SYSTEM: cls = SYSTEM;
            default:    cls = ILLEGAL;
        endcase
        return cls;
    endfunction

endpackage

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - combinational RV32I immediate extraction, sign-extended to XLEN
module imm_gen
    import rapid_pkg::*;
#(
    parameter int XLEN = 32
) (
    // Opcode bits are not needed here: the class already encodes the format.
    input  logic [31:7]     i_instruction,
    input  instr_class_t    i_class,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] imm32;

    always_comb begin
        imm32 = '0;
        case (i_class)
            ALU_I, LOAD, JALR, SYSTEM:
                imm32 = {{20{i_instruction[31]}}, i_instruction[31:20]};
            STORE:
                imm32 = {{20{i_instruction[31]}}, i_instruction[31:25], i_instruction[11:7]};
            BRANCH:
                imm32 = {{19{i_instruction[31]}}, i_instruction[31], i_instruction[7],
                         i_instruction[30:25], i_instruction[11:8], 1'b0};
            JAL:
                imm32 = {{11{i_instruction[31]}}, i_instruction[31], i_instruction[19:12],
                         i_instruction[20], i_instruction[30:21], 1'b0};
            LUI, AUIPC:
                imm32 = {i_instruction[31:12], 12'b0};
            default:
                imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(imm32));

endmodule

// File: rtl/instruction_decode.sv
// rtl/instruction_decode.sv - RV32I decode stage with valid/ready handshake, flush and illegal-instruction halt
module instruction_decode
    import rapid_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic            i_if_done,
    input  logic [XLEN-1:0] i_if_pc,
    input  logic [31:0]     i_if_instruction,
    output logic            o_if_ready,
    input  logic            i_flush,
    input  logic            i_ex_ready,
    output logic            o_valid,
    output logic [XLEN-1:0] o_pc,
    output logic [4:0]      o_rs1,
    output logic [4:0]      o_rs2,
    output logic [4:0]      o_rd,
    output logic [2:0]      o_funct3,
    output logic            o_funct7_b5,
    output logic [XLEN-1:0] o_imm,
    output instr_class_t    o_class,
    output logic [31:0]     o_decode_count,
    output id_state_t       o_state
);

    id_state_t       state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, imm_q, imm_d;
    logic [4:0]      rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
    logic [2:0]      funct3_q, funct3_d;
    logic            funct7_b5_q, funct7_b5_d;
    instr_class_t    class_q, class_d;
    logic [31:0]     count_q, count_d;

    instr_class_t    dec_class;
    logic [XLEN-1:0] dec_imm;
    logic            xfer_in, xfer_out, load_fields;

    assign dec_class = classify(i_if_instruction[6:0]);

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .i_instruction (i_if_instruction[31:7]),
        .i_class       (dec_class),
        .o_imm         (dec_imm)
    );

    assign o_if_ready = !i_reset && !i_flush &&
                        (state_q == ID_EMPTY || (state_q == ID_VALID && i_ex_ready));
    assign o_valid    = (state_q == ID_VALID);
    assign xfer_in    = i_if_done && o_if_ready;
    assign xfer_out   = o_valid && i_ex_ready;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        imm_d       = imm_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        funct3_d    = funct3_q;
        funct7_b5_d = funct7_b5_q;
        class_d     = class_q;
        count_d     = count_q;
        load_fields = 1'b0;

        // Flush wins over any handshake this cycle; a halted stage stays halted until reset.
        if (i_flush) begin
            if (state_q != ID_HALT) state_d = ID_EMPTY;
        end else begin
            case (state_q)
                ID_EMPTY: begin
                    if (xfer_in) begin
                        state_d     = ID_VALID;
                        load_fields = 1'b1;
                    end
                end
                ID_VALID: begin
                    if (xfer_out) begin
                        count_d = count_q + 32'd1;
                        if (class_q == ILLEGAL) state_d = ID_HALT;
                        else if (xfer_in)       load_fields = 1'b1;
                        else                    state_d = ID_EMPTY;
                    end
                end
                default: state_d = ID_HALT;
            endcase
        end

        if (load_fields) begin
            pc_d        = i_if_pc;
            imm_d       = dec_imm;
            rs1_d       = i_if_instruction[19:15];
            rs2_d       = (dec_class == ALU_R || dec_class == STORE || dec_class == BRANCH)
                          ? i_if_instruction[24:20] : 5'd0;
            rd_d        = (dec_class == STORE || dec_class == BRANCH) ? 5'd0 : i_if_instruction[11:7];
            funct3_d    = i_if_instruction[14:12];
            funct7_b5_d = i_if_instruction[30];
            class_d     = dec_class;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ID_EMPTY;
            pc_q        <= '0;
            imm_q       <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            funct3_q    <= '0;
            funct7_b5_q <= 1'b0;
            class_q     <= ILLEGAL;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            imm_q       <= imm_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            funct3_q    <= funct3_d;
            funct7_b5_q <= funct7_b5_d;
            class_q     <= class_d;
            count_q     <= count_d;
        end
    end

    assign o_pc           = pc_q;
    assign o_imm          = imm_q;
    assign o_rs1          = rs1_q;
    assign o_rs2          = rs2_q;
    assign o_rd           = rd_q;
    assign o_funct3       = funct3_q;
    assign o_funct7_b5    = funct7_b5_q;
    assign o_class        = class_q;
    assign o_decode_count = count_q;
    assign o_state        = state_q;

endmodule

// File: tb/tb_instruction_decode.sv
// tb/tb_instruction_decode.sv - directed and randomized checks of instruction_decode against a reference model
module tb_instruction_decode;
    import rapid_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        if_done = 1'b0;
    logic [31:0] if_pc = '0;
    logic [31:0] if_instr = '0;
    logic        flush = 1'b0;
    logic        ex_ready = 1'b0;

    logic         o_if_ready, o_valid, o_funct7_b5;
    logic [31:0]  o_pc, o_imm, o_decode_count;
    logic [4:0]   o_rs1, o_rs2, o_rd;
    logic [2:0]   o_funct3;
    instr_class_t o_class;
    id_state_t    o_state;

    always #5 clk = ~clk;

    instruction_decode #(.XLEN(32)) dut (
        .i_clk            (clk),
        .i_reset          (rst),
        .i_if_done        (if_done),
        .i_if_pc          (if_pc),
        .i_if_instruction (if_instr),
        .o_if_ready       (o_if_ready),
        .i_flush          (flush),
        .i_ex_ready       (ex_ready),
        .o_valid          (o_valid),
        .o_pc             (o_pc),
        .o_rs1            (o_rs1),
        .o_rs2            (o_rs2),
        .o_rd             (o_rd),
        .o_funct3         (o_funct3),
        .o_funct7_b5      (o_funct7_b5),
        .o_imm            (o_imm),
        .o_class          (o_class),
        .o_decode_count   (o_decode_count),
        .o_state          (o_state)
    );

    typedef struct {
        logic [31:0]  pc;
        logic [4:0]   rs1, rs2, rd;
        logic [2:0]   f3;
        logic         f7;
        logic [31:0]  imm;
        instr_class_t cls;
    } rec_t;

    int          n_checks = 0;
    int          n_fail = 0;
    rec_t        m_rec;
    bit          m_held = 0;
    bit          m_halt = 0;
    logic [31:0] m_count = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic rec_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
        rec_t r;
        int   imm;
        r.pc  = pc;
        r.rs1 = i[19:15];
        r.rs2 = i[24:20];
        r.rd  = i[11:7];
        r.f3  = i[14:12];
        r.f7  = i[30];
        if (i[1:0] != 2'b11) r.cls = ILLEGAL;
        else case (i[6:2])
            5'b01100: r.cls = ALU_R;
            5'b00100: r.cls = ALU_I;
            5'b00000: r.cls = LOAD;
            5'b01000: r.cls = STORE;
            5'b11000: r.cls = BRANCH;
            5'b11011: r.cls = JAL;
            5'b11001: r.cls = JALR;
            5'b01101: r.cls = LUI;
            5'b00101: r.cls = AUIPC;
            5'b11100: r.cls = SYSTEM;
            default:  r.cls = ILLEGAL;
        endcase
        imm = 0;
        case (r.cls)
            ALU_I, LOAD, JALR, SYSTEM: imm = $signed(i[31:20]);
            STORE:      imm = $signed({i[31:25], i[11:7]});
            BRANCH:     imm = $signed({i[31], i[7], i[30:25], i[11:8], 1'b0});
            JAL:        imm = $signed({i[31], i[19:12], i[20], i[30:21], 1'b0});
            LUI, AUIPC: imm = i & 32'hFFFF_F000;
            default:    imm = 0;
        endcase
        r.imm = imm;
        if (!(r.cls == ALU_R || r.cls == STORE || r.cls == BRANCH)) r.rs2 = 5'd0;
        if (r.cls == STORE || r.cls == BRANCH) r.rd = 5'd0;
        return r;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [6:0]  ops [0:9];
        int          k;
        ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73};
        w = $urandom();
        k = $urandom_range(0, 21);
        if (k < 20)       w[6:0] = ops[k / 2];
        else if (k == 20) w[6:0] = 7'h0F;
        else              w[1:0] = 2'b10;
        return w;
    endfunction

    task automatic chk_outputs();
        id_state_t exp_state;
        exp_state = m_halt ? ID_HALT : (m_held ? ID_VALID : ID_EMPTY);
        chk("valid", o_valid, m_held);
        chk("state", o_state, exp_state);
        chk("count", o_decode_count, m_count);
        if (m_held) begin
            chk("pc", o_pc, m_rec.pc);
            chk("rs1", o_rs1, m_rec.rs1);
            chk("rs2", o_rs2, m_rec.rs2);
            chk("rd", o_rd, m_rec.rd);
            chk("funct3", o_funct3, m_rec.f3);
            chk("funct7_b5", o_funct7_b5, m_rec.f7);
            chk("imm", o_imm, m_rec.imm);
            chk("class", o_class, m_rec.cls);
        end
    endtask

    // One clock with the currently driven inputs; model updated from the handshake rules.
    task automatic step();
        bit xin, xout, exp_ready;
        #1;
        exp_ready = !flush && !m_halt && (!m_held || ex_ready);
        chk("if_ready", o_if_ready, exp_ready);
        xin  = if_done && exp_ready;
        xout = m_held && ex_ready;
        @(posedge clk);
        #1;
        if (flush) begin
            if (!m_halt) m_held = 0;
        end else begin
            if (xout) begin
                m_count++;
                if (m_rec.cls == ILLEGAL) m_halt = 1;
                m_held = 0;
            end
            if (xin && !m_halt) begin
                m_held = 1;
                m_rec  = ref_decode(if_instr, if_pc);
            end
        end
        chk_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        if_done = 1'b1;
        ex_ready = 1'b1;
        flush = 1'b0;
        #1;
        chk("rst_valid", o_valid, 0);
        chk("rst_state", o_state, ID_EMPTY);
        chk("rst_count", o_decode_count, 0);
        chk("rst_class", o_class, ILLEGAL);
        chk("rst_rd", o_rd, 0);
        chk("rst_imm", o_imm, 0);
        chk("rst_pc", o_pc, 0);
        chk("rst_if_ready", o_if_ready, 0);
        @(posedge clk);
        #1;
        chk("rst_hold_if_ready", o_if_ready, 0);
        rst = 1'b0;
        if_done = 1'b0;
        ex_ready = 1'b0;
        m_held = 0;
        m_halt = 0;
        m_count = '0;
    endtask

    initial begin
        #2;
        do_reset();

        // addi x1,x0,5
        if_done = 1; if_pc = 32'h100; if_instr = 32'h0050_0093; ex_ready = 1;
        step();
        chk("addi_valid", o_valid, 1);
        chk("addi_class", o_class, ALU_I);
        chk("addi_rd", o_rd, 1);
        chk("addi_rs1", o_rs1, 0);
        chk("addi_imm", o_imm, 5);
        chk("addi_pc", o_pc, 32'h100);
        if_done = 0;
        step();

        // beq x0,x0,-4 stalled for three cycles while another word is offered
        if_done = 1; if_pc = 32'h104; if_instr = 32'hFE00_0EE3; ex_ready = 0;
        step();
        if_pc = 32'h108; if_instr = 32'h0010_0113;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("beq_imm", o_imm, 32'hFFFF_FFFC);
            chk("beq_stall_ready", o_if_ready, 0);
            chk("beq_stall_count", o_decode_count, 1);
        end
        if_done = 0; ex_ready = 1;
        step();
        chk("beq_release_count", o_decode_count, 2);

        // back-to-back stream of four
        do_reset();
        if_done = 1; ex_ready = 1;
        for (int i = 0; i < 4; i++) begin
            if_pc = 32'h200 + 4 * i;
            if_instr = {12'(i + 7), 5'd0, 3'b000, 5'(i + 1), 7'h13};
            step();
            chk("stream_valid", o_valid, 1);
        end
        if_done = 0;
        step();
        chk("stream_count", o_decode_count, 4);

        // flush beats simultaneous transfer-in and transfer-out
        if_done = 1; ex_ready = 0; if_instr = 32'h0030_8193; if_pc = 32'h300;
        step();
        flush = 1; ex_ready = 1; if_instr = 32'h0040_8213;
        step();
        chk("flush_valid", o_valid, 0);
        chk("flush_state", o_state, ID_EMPTY);
        chk("flush_count", o_decode_count, 4);
        flush = 0; if_done = 0;
        step();

        // asynchronous reset in the middle of a held transfer
        if_done = 1; ex_ready = 0; if_instr = 32'h0000_0297;
        step();
        do_reset();

        // illegal instruction halts until reset
        if_done = 1; ex_ready = 1; if_instr = 32'h0000_0000; if_pc = 32'h400;
        step();
        chk("illegal_class", o_class, ILLEGAL);
        if_done = 0;
        step();
        chk("halt_state", o_state, ID_HALT);
        if_done = 1; if_instr = 32'h0050_0093;
        step();
        chk("halt_ready", o_if_ready, 0);
        chk("halt_count", o_decode_count, 1);
        do_reset();
        chk("halt_reset_state", o_state, ID_EMPTY);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            if (m_halt && $urandom_range(0, 3) == 0) do_reset();
            if_done  = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 9) < 7);
            flush    = !m_halt && ($urandom_range(0, 24) == 0);
            if_pc    = $urandom();
            if_instr = rand_instr();
            step();
        end
        flush = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/instruction_decode.md
INSTRUCTION_DECODE -- requirements
Module: instruction_decode

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/PC width.
REQ-002 SHALL have port i_clk  in  1  clock; all state changes on rising edge.
REQ-003 SHALL have port i_reset  in  1  reset; asynchronous, active-high.
REQ-004 SHALL have port i_if_done  in  1  fetch stage holds a valid instruction.
REQ-005 SHALL have port i_if_pc  in  XLEN  PC of offered instruction.
REQ-006 SHALL have port i_if_instruction  in  32  offered RV32I instruction word.
REQ-007 SHALL have port o_if_ready  out  1  decode can accept this cycle; drives the fetch stage's pipeline-ready input.
REQ-008 SHALL have port i_flush  in  1  discard held and offered instruction (branch taken).
REQ-009 SHALL have port i_ex_ready  in  1  execute stage accepts o_valid data.
REQ-010 SHALL have port o_valid  out  1  decoded outputs valid.
REQ-011 SHALL have ports o_pc (XLEN), o_rs1/o_rs2/o_rd (5 each), o_funct3 (3), o_funct7_b5 (1), o_imm (XLEN), all out, decoded fields.
REQ-012 SHALL have port o_class  out  instr_class_t  instruction class (ALU_R, ALU_I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, ILLEGAL).
REQ-013 SHALL have port o_decode_count  out  32  number of instructions handed to execute.
REQ-014 SHALL have port o_state  out  id_state_t  current FSM state, for verification only.

Function
REQ-015 SHALL implement FSM states ID_EMPTY, ID_VALID, ID_HALT.
REQ-016 SHALL define transfer-in as i_if_done && o_if_ready at a rising edge; transfer-out as o_valid && i_ex_ready at a rising edge.
REQ-017 SHALL drive o_if_ready = !i_flush && (state==ID_EMPTY || (state==ID_VALID && i_ex_ready)); 0 in ID_HALT.
REQ-018 SHALL register all decoded outputs; transfer-in at edge N gives o_valid=1 and fields valid after edge N (1-cycle latency).
REQ-019 SHALL hold all outputs stable while o_valid=1 and i_ex_ready=0.
REQ-020 ID_EMPTY: transfer-in -> ID_VALID; else stay.
REQ-021 ID_VALID: transfer-out with transfer-in -> stay ID_VALID with new instruction (back-to-back, no bubble); transfer-out alone -> ID_EMPTY.
REQ-022 ID_VALID: transfer-out of an instruction with o_class==ILLEGAL -> ID_HALT; ID_HALT exits only via reset.
REQ-023 i_flush=1 at an edge -> ID_EMPTY, o_valid=0, offered instruction dropped; flush beats simultaneous transfer-in and transfer-out; o_decode_count unchanged by the flushed instruction.
REQ-024 SHALL sign-extend immediates to XLEN per RV32I I/S/B/U/J formats; B and J bit0 = 0; U = inst[31:12]<<12; R-type o_imm = 0.
REQ-025 SHALL classify by opcode[6:0]; any unlisted opcode, or inst[1:0]!=2'b11 -> ILLEGAL.
REQ-026 SHALL force o_rd=0 for STORE and BRANCH; o_rs2=0 for non-R/S/B formats.
REQ-027 o_decode_count SHALL increment by 1 per transfer-out, wrapping 0xFFFF_FFFF -> 0.

Reset
REQ-028 On i_reset: state=ID_EMPTY, o_valid=0, all field outputs 0, o_class=ILLEGAL, o_decode_count=0, asynchronously, including mid-transfer.
REQ-029 o_if_ready SHALL be 0 while i_reset is asserted and 1 in the first cycle after release.

Structure
REQ-030 id_state_t, instr_class_t and RV32I opcode constants SHALL live in rapid_pkg.
REQ-031 Immediate extraction SHALL be a combinational sub-module imm_gen (instruction, class -> XLEN immediate).

Verification
REQ-032 Offer 0x00500093 (addi x1,x0,5) at PC 0x100 with i_ex_ready=1 -> next cycle o_valid=1, o_class=ALU_I, o_rd=1, o_rs1=0, o_imm=5, o_pc=0x100.
REQ-033 Offer 0xFE000EE3 (beq x0,x0,-4) with i_ex_ready=0 for 3 cycles -> o_imm=0xFFFF_FFFC held stable, o_if_ready=0, count unchanged; then i_ex_ready=1 -> count +1.
REQ-034 Stream 4 instructions with i_if_done=i_ex_ready=1 -> o_valid continuous, count=4, no bubble.
REQ-035 Assert i_flush with i_if_done=1 while in ID_VALID -> next cycle o_valid=0, state ID_EMPTY, count unchanged.
REQ-036 Offer 0x00000000 -> o_class=ILLEGAL; after transfer-out state=ID_HALT, o_if_ready=0; i_reset pulse -> ID_EMPTY, count=0.
